// File: rtl/stu_pkg.sv
// Shared types and default widths for the speculative store retire path.
package stu_pkg;

    localparam int unsigned StuAddrW = 32;
    localparam int unsigned StuDataW = 32;
    localparam int unsigned StuDepth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrain,
        StFlush
    } retire_state_t;

endpackage

// File: rtl/stu_sb_fifo.sv
// In-order store buffer: circular storage with head/tail/count, push, pop and sync clear.
module stu_sb_fifo
    import stu_pkg::*;
#(
    parameter int unsigned ADDR_W = StuAddrW,
    parameter int unsigned DATA_W = StuDataW,
    parameter int unsigned DEPTH  = StuDepth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic [DATA_W/8-1:0]        push_strb,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [DATA_W/8-1:0]        head_strb,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W/8-1:0] strb_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
            strb_q[tail_q] <= push_strb;
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign head_strb = strb_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/stu_spec_retire.sv
// Buffers speculative stores during an L2 task; drains them on commit, discards on squash/cancel.
module stu_spec_retire
    import stu_pkg::*;
#(
    parameter int unsigned ADDR_W = StuAddrW,
    parameter int unsigned DATA_W = StuDataW,
    parameter int unsigned DEPTH  = StuDepth
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l2_spec_task_active_in,
    input  logic                commit_in,
    input  logic                squash_in,
    input  logic                sb_wr_valid_in,
    input  logic [ADDR_W-1:0]   sb_wr_addr_in,
    input  logic [DATA_W-1:0]   sb_wr_data_in,
    input  logic [DATA_W/8-1:0] sb_wr_strb_in,
    output logic                sb_wr_ready_out,
    output logic                sb_overflow_out,
    output logic                mem_wr_valid_out,
    output logic [ADDR_W-1:0]   mem_wr_addr_out,
    output logic [DATA_W-1:0]   mem_wr_data_out,
    output logic [DATA_W/8-1:0] mem_wr_strb_out,
    input  logic                mem_wr_ready_in,
    output logic                spec_flush_out,
    output logic                retire_busy_out,
    output logic                retire_done_out
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    retire_state_t       state_q, state_d;
    logic                sb_push, sb_pop, sb_clr, sb_full, sb_empty, last_pop;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [DATA_W/8-1:0] head_strb;
    logic [CntW-1:0]     sb_count;

    stu_sb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sb_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (sb_clr),
        .push      (sb_push),
        .push_addr (sb_wr_addr_in),
        .push_data (sb_wr_data_in),
        .push_strb (sb_wr_strb_in),
        .pop       (sb_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_strb (head_strb),
        .count     (sb_count),
        .full      (sb_full),
        .empty     (sb_empty)
    );

    assign last_pop = sb_pop && (sb_count == CntW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (l2_spec_task_active_in) state_d = StCollect;
            StCollect: begin
                // Squash beats commit; losing the task without a verdict discards it.
                if (squash_in)                   state_d = StFlush;
                else if (commit_in)              state_d = StDrain;
                else if (!l2_spec_task_active_in) state_d = StFlush;
            end
            StDrain:   if (sb_empty || last_pop) state_d = StIdle;
            StFlush:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        sb_wr_ready_out  = (state_q == StCollect) && !sb_full;
        sb_overflow_out  = (state_q == StCollect) && sb_wr_valid_in && sb_full;
        sb_push          = sb_wr_valid_in && sb_wr_ready_out;
        mem_wr_valid_out = (state_q == StDrain) && !sb_empty;
        sb_pop           = mem_wr_valid_out && mem_wr_ready_in;
        sb_clr           = (state_q == StFlush);
        spec_flush_out   = (state_q == StFlush);
        retire_busy_out  = (state_q == StDrain) || (state_q == StFlush);
        retire_done_out  = (state_q == StFlush) ||
                           ((state_q == StDrain) && (sb_empty || last_pop));
        mem_wr_addr_out  = mem_wr_valid_out ? head_addr : '0;
        mem_wr_data_out  = mem_wr_valid_out ? head_data : '0;
        mem_wr_strb_out  = mem_wr_valid_out ? head_strb : '0;
    end

endmodule

// File: tb/tb_stu_spec_retire.sv
// Randomized and directed bench for stu_spec_retire against a queue-based store-buffer model.
module tb_stu_spec_retire;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } st_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          active = 1'b0, commit = 1'b0, squash = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [SW-1:0] wr_strb = '0;
    logic          wr_ready, overflow, mem_valid, mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [SW-1:0] mem_strb;
    logic          flush, busy, done;

    st_t mq[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    stu_spec_retire #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .l2_spec_task_active_in (active),
        .commit_in              (commit),
        .squash_in              (squash),
        .sb_wr_valid_in         (wr_valid),
        .sb_wr_addr_in          (wr_addr),
        .sb_wr_data_in          (wr_data),
        .sb_wr_strb_in          (wr_strb),
        .sb_wr_ready_out        (wr_ready),
        .sb_overflow_out        (overflow),
        .mem_wr_valid_out       (mem_valid),
        .mem_wr_addr_out        (mem_addr),
        .mem_wr_data_out        (mem_data),
        .mem_wr_strb_out        (mem_strb),
        .mem_wr_ready_in        (mem_ready),
        .spec_flush_out         (flush),
        .retire_busy_out        (busy),
        .retire_done_out        (done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic st_t rnd_store();
        st_t s;
        s.a = $urandom;
        s.d = $urandom;
        s.s = SW'($urandom);
        return s;
    endfunction

    // Drive one store (or none) in a COLLECT cycle and check acceptance against model occupancy.
    task automatic collect_cycle(input bit v, input st_t s, input string tag);
        bit exp_full;
        wr_valid = v;
        wr_addr  = s.a;
        wr_data  = s.d;
        wr_strb  = s.s;
        #1;
        exp_full = (mq.size() >= DEPTH);
        n_checks++;
        if ({wr_ready, overflow, done, busy} !== {!exp_full, v && exp_full, 1'b0, 1'b0})
            $display("FAIL %s collect rdy/ovf/done/busy got %b%b%b%b exp %b%b00", tag,
                     wr_ready, overflow, done, busy, !exp_full, v && exp_full);
        else n_pass++;
        if (v && !exp_full) mq.push_back(s);
    endtask

    task automatic begin_task(input string tag);
        active   = 1'b1;
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if ({wr_ready, busy, mem_valid} !== 3'b000)
            $display("FAIL %s idle rdy/busy/mvalid got %b%b%b exp 000", tag, wr_ready, busy,
                     mem_valid);
        else n_pass++;
        cyc();
    endtask

    task automatic push_store(input st_t s, input string tag);
        collect_cycle(1'b1, s, tag);
        cyc();
        wr_valid = 1'b0;
    endtask

    // kind: 0 commit, 1 squash, 2 cancel (active drop), 3 commit+squash
    task automatic verdict(input int kind, input bit with_store, input string tag);
        commit = (kind == 0) || (kind == 3);
        squash = (kind == 1) || (kind == 3);
        active = (kind != 2);
        collect_cycle(with_store, rnd_store(), tag);
        cyc();
        commit   = 1'b0;
        squash   = 1'b0;
        wr_valid = 1'b0;
        active   = 1'b0;
    endtask

    task automatic expect_drain(input int stall, input bit rnd, input string tag);
        int  n = 0;
        bit  fin = 1'b0;
        bit  rdy, exp_v, exp_done;
        while (!fin && n < 64) begin
            rdy       = (n < stall) ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
            mem_ready = rdy;
            squash    = rnd ? 1'($urandom) : 1'b0;
            commit    = rnd ? 1'($urandom) : 1'b0;
            #1;
            exp_v    = (mq.size() != 0);
            exp_done = !exp_v || (rdy && mq.size() == 1);
            n_checks++;
            if ({mem_valid, done, busy, flush, wr_ready} !== {exp_v, exp_done, 3'b100})
                $display("FAIL %s drain v/done/busy/flush/rdy got %b%b%b%b%b exp %b%b100", tag,
                         mem_valid, done, busy, flush, wr_ready, exp_v, exp_done);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if ({mem_addr, mem_data, mem_strb} !== mq[0])
                    $display("FAIL %s drain payload got %h/%h/%h exp %h/%h/%h", tag, mem_addr,
                             mem_data, mem_strb, mq[0].a, mq[0].d, mq[0].s);
                else n_pass++;
                if (rdy) void'(mq.pop_front());
            end
            cyc();
            n++;
            fin = exp_done;
        end
        mem_ready = 1'b0;
        squash    = 1'b0;
        commit    = 1'b0;
        n_checks++;
        if (!fin) $display("FAIL %s drain timeout got running exp done", tag);
        else n_pass++;
        #1;
        n_checks++;
        if ({busy, mem_valid, done} !== 3'b000)
            $display("FAIL %s post-drain busy/v/done got %b%b%b exp 000", tag, busy, mem_valid,
                     done);
        else n_pass++;
    endtask

    task automatic expect_flush(input string tag);
        #1;
        n_checks++;
        if ({flush, done, busy, mem_valid, wr_ready} !== 5'b11100)
            $display("FAIL %s flush f/done/busy/v/rdy got %b%b%b%b%b exp 11100", tag, flush,
                     done, busy, mem_valid, wr_ready);
        else n_pass++;
        mq.delete();
        cyc();
        n_checks++;
        if ({flush, done, busy} !== 3'b000)
            $display("FAIL %s post-flush f/done/busy got %b%b%b exp 000", tag, flush, done,
                     busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        #3;
        n_checks++;
        if ({wr_ready, overflow, mem_valid, mem_addr, mem_data, mem_strb, flush, busy, done}
            !== '0)
            $display("FAIL reset outputs got nonzero exp 0");
        else n_pass++;
        cyc();
        rst    = 1'b1;
        commit = 1'b1;
        squash = 1'b1;
        cyc();
        commit = 1'b0;
        squash = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, flush} !== 3'b000)
            $display("FAIL idle_verdict busy/done/flush got %b%b%b exp 000", busy, done, flush);
        else n_pass++;
    endtask

    task automatic three_stores();
        st_t s;
        for (int i = 0; i < 3; i++) begin
            s.a = 32'h100 + 32'(4 * i);
            s.d = 32'h11 * 32'(i + 1);
            s.s = '1;
            push_store(s, "store3");
        end
    endtask

    task automatic test_commit();
        begin_task("commit");
        three_stores();
        verdict(0, 1'b0, "commit");
        expect_drain(0, 1'b0, "commit");
    endtask

    task automatic test_squash();
        begin_task("squash");
        three_stores();
        verdict(1, 1'b0, "squash");
        expect_flush("squash");
        begin_task("after_squash");
        verdict(0, 1'b0, "after_squash");
        expect_drain(0, 1'b0, "after_squash");
    endtask

    task automatic test_overflow();
        begin_task("overflow");
        for (int i = 0; i < DEPTH; i++) push_store(rnd_store(), "fill");
        push_store(rnd_store(), "ninth");
        verdict(0, 1'b1, "overflow");
        expect_drain(0, 1'b0, "overflow");
    endtask

    task automatic test_backpressure();
        begin_task("bp");
        push_store(rnd_store(), "bp");
        push_store(rnd_store(), "bp");
        verdict(0, 1'b0, "bp");
        expect_drain(3, 1'b0, "bp");
    endtask

    task automatic test_empty_and_cancel();
        begin_task("empty_commit");
        verdict(0, 1'b0, "empty_commit");
        expect_drain(0, 1'b0, "empty_commit");
        begin_task("cancel");
        push_store(rnd_store(), "cancel");
        verdict(2, 1'b1, "cancel");
        expect_flush("cancel");
        begin_task("both");
        push_store(rnd_store(), "both");
        verdict(3, 1'b0, "both");
        expect_flush("both");
    endtask

    task automatic test_reset_mid_drain();
        begin_task("rst_drain");
        for (int i = 0; i < 4; i++) push_store(rnd_store(), "rst_drain");
        verdict(0, 1'b0, "rst_drain");
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid, mem_addr, mem_data, mem_strb} !== {1'b1, mq[0]})
            $display("FAIL rst_drain first got %b %h exp 1 %h", mem_valid, mem_addr, mq[0].a);
        else n_pass++;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({wr_ready, overflow, mem_valid, mem_addr, mem_data, mem_strb, flush, busy, done}
            !== '0)
            $display("FAIL rst_drain outputs got v=%b busy=%b exp 0", mem_valid, busy);
        else n_pass++;
        mq.delete();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({mem_valid, busy, done} !== 3'b000)
                $display("FAIL rst_drain after v/busy/done got %b%b%b exp 000", mem_valid, busy,
                         done);
            else n_pass++;
            cyc();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_random();
        int kind;
        for (int t = 0; t < 30; t++) begin
            begin_task("rnd");
            for (int i = 0; i < int'($urandom_range(0, 12)); i++) begin
                collect_cycle(1'($urandom_range(0, 3) != 0), rnd_store(), "rnd");
                cyc();
                wr_valid = 1'b0;
            end
            kind = $urandom_range(0, 4);
            if (kind == 4) kind = 0;
            verdict(kind, 1'($urandom), "rnd");
            if (kind == 0) expect_drain(0, 1'b1, "rnd");
            else           expect_flush("rnd");
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_squash();
        test_overflow();
        test_backpressure();
        test_empty_and_cancel();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
